store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 29 ++
 rtl/store_buffer.sv | 81 ++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU store/load ports and data-memory drain port of the store buffer.
interface store_buffer_if #(parameter int DEPTH = 4);
  logic                     st_valid;
  logic [31:0]              st_addr;
  logic [31:0]              st_data;
  logic [1:0]               st_type;
  logic [31:0]              st_pc;
  logic                     st_ready;
  logic                     ld_valid;
  logic [31:0]              ld_addr;
  logic                     ld_stall;
  logic                     dm_str;
  logic [31:0]              dm_A;
  logic [31:0]              dm_data;
  logic [1:0]               dm_type;
  logic [31:0]              dm_pc;
  logic                     dm_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     err;
  modport slave (
    input  st_valid, st_addr, st_data, st_type, st_pc, ld_valid, ld_addr, dm_ready,
    output st_ready, ld_stall, dm_str, dm_A, dm_data, dm_type, dm_pc, count, empty, err
  );
  modport master (
    output st_valid, st_addr, st_data, st_type, st_pc, ld_valid, ld_addr, dm_ready,
    input  st_ready, ld_stall, dm_str, dm_A, dm_data, dm_type, dm_pc, count, empty, err
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending CPU stores draining to data memory, with load-hazard stall.
module store_buffer #(parameter int DEPTH = 4) (
  input logic          clk,
  input logic          clr,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] addr_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [31:0] pc_d [DEPTH];
  logic [1:0]  type_q [DEPTH];
  logic [1:0]  type_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d;
  logic empty, full, accept, mis, enq, deq, stall;
  always_comb begin
    empty = count_q == '0;
    full = count_q == CW'(DEPTH);
    accept = bus.st_valid && !full;
    mis = (bus.st_type == 2'b00 && bus.st_addr[1:0] != 2'b00) || (bus.st_type == 2'b11 && bus.st_addr[0]);
    enq = accept && bus.st_type != 2'b10 && !mis;
    deq = !empty && bus.dm_ready;
    addr_d = addr_q;
    data_d = data_q;
    pc_d = pc_q;
    type_d = type_q;
    if (enq) begin
      addr_d[tail_q] = bus.st_addr;
      data_d[tail_q] = bus.st_data;
      pc_d[tail_q] = bus.st_pc;
      type_d[tail_q] = bus.st_type;
    end
    head_d = head_q + PW'(deq);
    tail_d = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(deq);
    err_d = accept && mis;
    // An entry is live when its distance from head is below the occupancy.
    stall = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (bus.ld_valid && CW'(off) < count_q && addr_q[i][31:2] == bus.ld_addr[31:2]) stall = 1'b1;
    end
  end
  assign bus.st_ready = !full;
  assign bus.empty = empty;
  assign bus.count = count_q;
  assign bus.err = err_q;
  assign bus.ld_stall = stall;
  assign bus.dm_str = !empty;
  assign bus.dm_A = empty ? '0 : addr_q[head_q];
  assign bus.dm_data = empty ? '0 : data_q[head_q];
  assign bus.dm_type = empty ? '0 : type_q[head_q];
  assign bus.dm_pc = empty ? '0 : pc_q[head_q];
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
      pc_q <= '{default: '0};
      type_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      pc_q <= pc_d;
      type_q <= type_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
endmodule
